// File: rtl/lc3_stage_sequencer_if.sv
// Sequencer <-> control/memory bundle: RUN/IR/MEM_READY in, STAGE bus and status out.
// Optional SEQ_SINGLE_STEP_EN adds the STEP input to the bundle.
interface lc3_stage_sequencer_if #(
   parameter int unsigned COUNT_W = 16
) ();

   logic               run;
   logic [15:0]        instruction;
   logic               mem_ready;
`ifdef SEQ_SINGLE_STEP_EN
   logic               step;
`endif
   logic [1:0]         stage;
   logic               stage_valid;
   logic               mem_req;
   logic               mem_wr;
   logic               retire;
   logic               halted;
   logic               bus_err;
   logic [COUNT_W-1:0] instr_count;

`ifdef SEQ_SINGLE_STEP_EN
   modport master (
      input  run, instruction, mem_ready, step,
      output stage, stage_valid, mem_req, mem_wr, retire, halted, bus_err, instr_count
   );

   modport slave (
      output run, instruction, mem_ready, step,
      input  stage, stage_valid, mem_req, mem_wr, retire, halted, bus_err, instr_count
   );
`else
   modport master (
      input  run, instruction, mem_ready,
      output stage, stage_valid, mem_req, mem_wr, retire, halted, bus_err, instr_count
   );

   modport slave (
      output run, instruction, mem_ready,
      input  stage, stage_valid, mem_req, mem_wr, retire, halted, bus_err, instr_count
   );
`endif

endinterface

// File: rtl/lc3_stage_sequencer.sv
// LC3 multi-cycle stage sequencer: FETCH/EXEC/INDIR/MEM over one shared memory port.
// Optional single-step mode (STEP input) is enabled by defining SEQ_SINGLE_STEP_EN.
module lc3_stage_sequencer #(
   parameter int unsigned COUNT_W = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input logic                   clk_i,
   input logic                   reset_i,
   lc3_stage_sequencer_if.master seq_io
);

   localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WaitW-1:0] WaitLimit = WaitW'(TIMEOUT);

   localparam logic [3:0] OpLd   = 4'b0010;
   localparam logic [3:0] OpLdr  = 4'b0110;
   localparam logic [3:0] OpSt   = 4'b0011;
   localparam logic [3:0] OpStr  = 4'b0111;
   localparam logic [3:0] OpLdi  = 4'b1010;
   localparam logic [3:0] OpSti  = 4'b1011;
   localparam logic [3:0] OpTrap = 4'b1111;
   localparam logic [7:0] TrapHalt = 8'h25;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StIndir,
      StMem,
      StHalt
   } state_e;

   state_e             state_q, state_d;
   logic               retire_q, retire_d;
   logic               bus_err_q, bus_err_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [WaitW-1:0]   wait_q, wait_d;

   logic [3:0] opcode;
   logic       is_store;
   logic       mem_stage;
   logic       start;
   logic       keep_running;
   logic       done;
   logic [1:0] stage;
   logic       unused_instr;

   assign opcode       = seq_io.instruction[15:12];
   assign unused_instr = ^seq_io.instruction[11:8];
   assign is_store     = (opcode == OpSt) || (opcode == OpStr) || (opcode == OpSti);
   assign mem_stage    = state_q inside {StFetch, StIndir, StMem};

`ifdef SEQ_SINGLE_STEP_EN
   logic step_q;

   // One instruction per STEP rising edge; every retire falls back to IDLE.
   assign start        = seq_io.run && seq_io.step && !step_q;
   assign keep_running = 1'b0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         step_q <= 1'b0;
      end else begin
         step_q <= seq_io.step;
      end
   end
`else
   assign start        = seq_io.run;
   assign keep_running = seq_io.run;
`endif

   always_comb begin
      state_d   = state_q;
      retire_d  = 1'b0;
      bus_err_d = bus_err_q;
      count_d   = count_q;
      wait_d    = '0;
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            if (seq_io.mem_ready) state_d = StExec;
         end
         StExec: begin
            case (opcode)
               OpLd, OpLdr, OpSt, OpStr: state_d = StMem;
               OpLdi, OpSti:             state_d = StIndir;
               OpTrap: begin
                  if (seq_io.instruction[7:0] == TrapHalt) begin
                     retire_d = 1'b1;
                     state_d  = StHalt;
                  end else begin
                     done = 1'b1;
                  end
               end
               default: done = 1'b1;
            endcase
         end
         StIndir: begin
            if (seq_io.mem_ready) state_d = StMem;
         end
         StMem: begin
            if (seq_io.mem_ready) done = 1'b1;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase

      // A MEM_READY in the limit cycle still completes the access.
      if (mem_stage && !seq_io.mem_ready) begin
         if ((TIMEOUT != 0) && (wait_q == WaitLimit)) begin
            state_d   = StHalt;
            bus_err_d = 1'b1;
         end else begin
            wait_d = wait_q + WaitW'(1);
         end
      end

      if (done) begin
         retire_d = 1'b1;
         state_d  = keep_running ? StFetch : StIdle;
      end

      if (retire_d) count_d = count_q + COUNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         retire_q  <= 1'b0;
         bus_err_q <= 1'b0;
         count_q   <= '0;
         wait_q    <= '0;
      end else begin
         state_q   <= state_d;
         retire_q  <= retire_d;
         bus_err_q <= bus_err_d;
         count_q   <= count_d;
         wait_q    <= wait_d;
      end
   end

   always_comb begin
      stage = 2'd0;
      case (state_q)
         StExec:  stage = 2'd1;
         StIndir: stage = 2'd2;
         StMem:   stage = 2'd3;
         default: stage = 2'd0;
      endcase
   end

   assign seq_io.stage       = stage;
   assign seq_io.stage_valid = state_q inside {StFetch, StExec, StIndir, StMem};
   assign seq_io.mem_req     = mem_stage;
   assign seq_io.mem_wr      = (state_q == StMem) && is_store;
   assign seq_io.retire      = retire_q;
   assign seq_io.halted      = (state_q == StHalt);
   assign seq_io.bus_err     = bus_err_q;
   assign seq_io.instr_count = count_q;

   wr_implies_req: assert property (@(posedge clk_i) disable iff (reset_i)
      seq_io.mem_wr |-> seq_io.mem_req);
   halt_is_quiet: assert property (@(posedge clk_i) disable iff (reset_i)
      seq_io.halted |-> (!seq_io.mem_req && !seq_io.stage_valid));
   retire_is_pulse: assert property (@(posedge clk_i) disable iff (reset_i)
      seq_io.retire |=> !seq_io.retire);

endmodule

// File: doc/lc3_stage_sequencer.md
Name: lc3_stage_sequencer

Overview:
- Multi-cycle stage sequencer for the LC3 core. It drives the STAGE bus consumed by the instruction decode/control logic.
- Walks each instruction through fetch, execute and optional memory stages, handshaking with the single shared memory port.
- Handles run/halt, TRAP x25 halt, memory timeouts and a retired-instruction counter.

Parameters:
- COUNT_W, 16, width of retired-instruction counter INSTR_COUNT.
- TIMEOUT, 15, max cycles a memory stage waits for MEM_READY before bus error; 0 disables the timeout.

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- RUN  in  1  level; high allows new instructions to start
- INSTRUCTION  in  16  current IR contents; valid from EXEC onward
- MEM_READY  in  1  memory completes the current request this cycle
- STAGE  out  2  0=FETCH 1=EXEC 2=INDIR 3=MEM
- STAGE_VALID  out  1  STAGE is meaningful (low in IDLE/HALT)
- MEM_REQ  out  1  memory access request, held until accepted
- MEM_WR  out  1  request is a write; only meaningful with MEM_REQ
- RETIRE  out  1  one-cycle pulse when an instruction completes
- HALTED  out  1  sequencer in HALT state
- BUS_ERR  out  1  sticky; a memory stage timed out
- INSTR_COUNT  out  COUNT_W  retired instructions, wraps modulo 2^COUNT_W

Behaviour:
- Reset: state=IDLE; STAGE=0, STAGE_VALID=0, MEM_REQ=0, MEM_WR=0, RETIRE=0, HALTED=0, BUS_ERR=0, INSTR_COUNT=0, wait counter=0.
- RESET overrides everything, including mid-access. MEM_REQ is low in the first cycle after the reset edge.
- States: IDLE, FETCH, EXEC, INDIR, MEM, HALT. STAGE is the encoding above in FETCH/EXEC/INDIR/MEM; 0 otherwise.
- IDLE -> FETCH when RUN=1.
- FETCH:
  - MEM_REQ=1, MEM_WR=0.
  - Completes in the cycle MEM_READY=1 (same-cycle accept allowed) -> EXEC next cycle. Minimum latency 1 cycle.
- EXEC: always exactly 1 cycle. Opcode = INSTRUCTION[15:12].
  - LD 0010, LDR 0110, ST 0011, STR 0111 -> MEM.
  - LDI 1010, STI 1011 -> INDIR.
  - TRAP 1111 with INSTRUCTION[7:0]=x25 -> retire, then HALT.
  - All others (incl. BR/JMP/JSR/RTI/ALU ops) -> retire; then FETCH if RUN=1, else IDLE.
- INDIR: pointer read, MEM_REQ=1, MEM_WR=0. Completes on MEM_READY -> MEM.
- MEM:
  - MEM_REQ=1. MEM_WR=1 for ST/STR/STI, 0 for loads.
  - Completes on MEM_READY -> retire; then FETCH if RUN=1, else IDLE.
- Retire:
  - RETIRE=1 for exactly one cycle: the cycle after the final stage completes, coincident with the first cycle of the next state.
  - INSTR_COUNT increments by 1 on that cycle, wrapping from all-ones to 0.
- RUN low mid-instruction: the current instruction finishes; stop at the boundary (IDLE). No partial abort.
- Timeout (TIMEOUT>0):
  - Wait counter clears on entry to each memory stage and increments each cycle MEM_READY=0.
  - When it reaches TIMEOUT with MEM_READY still 0: BUS_ERR<=1, MEM_REQ drops next cycle, -> HALT. The instruction does not retire.
  - MEM_READY arriving in the same cycle the count reaches TIMEOUT counts as success.
- HALT: HALTED=1, STAGE_VALID=0, MEM_REQ=0. Left only by RESET; RUN is ignored.
- MEM_READY sampled outside memory stages is ignored.
- INSTRUCTION is sampled only in EXEC; in INDIR/MEM it is used only for the MEM_WR decode.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: adds input STEP (1 bit, pulse).
  - After every retire, the sequencer enters IDLE regardless of RUN.
  - IDLE -> FETCH requires RUN=1 and STEP=1 in the same cycle.
  - A STEP held high for multiple cycles executes one instruction only; a new rising edge is required.
- Not defined: no STEP port; runs continuously while RUN=1.

Test Plan:
- Reset, RUN=1, ADD x1201, MEM_READY always 1 -> STAGE 0,1,0,1...; RETIRE every 2nd cycle; INSTR_COUNT=3 after 3 instructions.
- LDR x6042, MEM_READY delayed 3 cycles in FETCH and 2 in MEM -> MEM_REQ held steady throughout; MEM_WR=0; STAGE 0,0,0,0,1,3,3,3; single RETIRE.
- STI xB1FF, MEM_READY=1 -> STAGE 0,1,2,3; MEM_WR=0 in INDIR and 1 in MEM; retire once.
- TRAP xF025 -> retire, HALTED=1, STAGE_VALID=0; RUN toggled -> stays halted; RESET -> IDLE, INSTR_COUNT=0.
- TIMEOUT=4, MEM_READY=0 forever in FETCH -> BUS_ERR=1 after 4 wait cycles, HALT, no RETIRE; RESET asserted mid-wait in a separate run -> MEM_REQ=0 next cycle, all outputs at reset values.
- COUNT_W=4, 17 NOPs (x0000 BR never) -> INSTR_COUNT wraps 15->0 and ends at 1. With SEQ_SINGLE_STEP_EN, 3 STEP pulses -> exactly 3 retires.
